// File: rtl/seq_divider_32b_if.sv
// Request/response bundle between the execute-stage datapath and the iterative divider.
interface seq_divider_32b_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_32b.sv
// Restoring shift-subtract divider, one quotient bit per clock, with sign
// handling around an unsigned core and a divide-by-zero short path.
module seq_divider_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider_32b_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x, input logic en);
    abs_val = (en && x[WIDTH-1]) ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    neg_if = en ? WIDTH'(-x) : x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    // Shifted partial remainder needs one extra bit: divisor may reach 2^WIDTH-1.
    rem_sh      = {rem_q, quo_q[WIDTH-1]};
    trial       = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH+1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          quo_d   = abs_val(bus.dividend, bus.signed_op);
          dvs_d   = abs_val(bus.divisor, bus.signed_op);
          neg_q_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_r_d = bus.signed_op & bus.dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            // Raw dividend parked in rem_q so it is returned unmodified.
            rem_d   = bus.dividend;
            state_d = FINISH;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = rem_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = neg_if(quo_q, neg_q_q);
          remainder_d = neg_if(rem_q, neg_r_q);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
